// File: rtl/dsm_cic_decimator.sv
// -----------------------------------------------------------------------------
// dsm_cic_decimator
//
// Purpose:
//   Third-order CIC (sinc^3) decimator that turns the 1-bit density stream of
//   the delta-sigma modulator back into a DOUT_W-bit unsigned sample. The
//   decimation ratio is R = 2^RLOG with a differential delay of 1, so one
//   output sample is produced per R accepted input bits.
//
// Ports:
//   clock       in   1       system clock, rising edge
//   reset       in   1       synchronous, active-high; clears all state
//   din         in   1       modulator bitstream bit (1 = +full-scale density)
//   din_valid   in   1       din is consumed only on cycles where this is 1
//   dout        out  DOUT_W  reconstructed unsigned sample (held between strobes)
//   dout_valid  out  1       single-cycle strobe marking a new dout
//
// Parameters:
//   RLOG    log2 of the decimation ratio, 1..8, with 3*RLOG <= DOUT_W
//   DOUT_W  output sample width
// -----------------------------------------------------------------------------
module dsm_cic_decimator #(
  parameter int RLOG   = 6,
  parameter int DOUT_W = 20
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              din,
  input  logic              din_valid,
  output logic [DOUT_W-1:0] dout,
  output logic              dout_valid
);

  // Full-scale CIC gain is R^3 = 2^(3*RLOG); one extra bit lets the all-ones
  // frame (exactly R^3) be represented without aliasing to zero.
  localparam int IW    = 3 * RLOG + 1;
  localparam int SHIFT = DOUT_W - 3 * RLOG;

  // ---------------------------------------------------------------------------
  // Integrator section (runs at input rate, frozen on din_valid=0)
  // ---------------------------------------------------------------------------
  logic [IW-1:0]   int1_q, int2_q, int3_q;
  logic [IW-1:0]   int1_d, int2_d, int3_d;
  logic [RLOG-1:0] decim_cnt_q;
  logic [1:0]      warm_q;
  logic            tick;

  // Each stage chains the value the previous stage is producing this cycle,
  // so the captured int3_d already includes the current input bit.
  always_comb begin
    int1_d = int1_q + IW'(din);
    int2_d = int2_q + int1_d;
    int3_d = int3_q + int2_d;
  end

  // Count is R-1 exactly when all RLOG bits are set.
  assign tick = din_valid && (&decim_cnt_q);

  // ---------------------------------------------------------------------------
  // Comb section (runs at decimated rate). Every stage carries a valid bit and
  // a strobe-enable bit so a tick can enter every cycle if needed (RLOG=1).
  // Stage 0: comb input capture  (edge 0 = tick edge)
  // Stage 1: C1 = x  - x(-1)     (edge 1)
  // Stage 2: C2 = C1 - C1(-1)    (edge 2)
  // Stage 3: C3 = C2 - C2(-1)    (edge 3)
  // Output : scale + saturate    (edge 4)
  // ---------------------------------------------------------------------------
  logic [IW-1:0] comb_in_q, comb_in_dly_q;
  logic [IW-1:0] comb1_q, comb1_dly_q;
  logic [IW-1:0] comb2_q, comb2_dly_q;
  logic [IW-1:0] comb3_q;
  logic          stg0_vld_q, stg1_vld_q, stg2_vld_q, stg3_vld_q;
  logic          stg0_stb_q, stg1_stb_q, stg2_stb_q, stg3_stb_q;

  logic [DOUT_W:0]   scaled_wide;
  logic [DOUT_W-1:0] dout_d;
  logic [DOUT_W-1:0] dout_q;
  logic              dout_valid_q;

  // Left-align the comb result in the output word. Only the all-ones frame
  // reaches 2^DOUT_W, which is clamped to the largest representable code.
  always_comb begin
    scaled_wide = (DOUT_W + 1)'(comb3_q) << SHIFT;
    if (scaled_wide[DOUT_W]) begin
      dout_d = '1;
    end else begin
      dout_d = scaled_wide[DOUT_W-1:0];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      int1_q        <= '0;
      int2_q        <= '0;
      int3_q        <= '0;
      decim_cnt_q   <= '0;
      warm_q        <= '0;
      comb_in_q     <= '0;
      comb_in_dly_q <= '0;
      comb1_q       <= '0;
      comb1_dly_q   <= '0;
      comb2_q       <= '0;
      comb2_dly_q   <= '0;
      comb3_q       <= '0;
      stg0_vld_q    <= 1'b0;
      stg1_vld_q    <= 1'b0;
      stg2_vld_q    <= 1'b0;
      stg3_vld_q    <= 1'b0;
      stg0_stb_q    <= 1'b0;
      stg1_stb_q    <= 1'b0;
      stg2_stb_q    <= 1'b0;
      stg3_stb_q    <= 1'b0;
      dout_q        <= '0;
      dout_valid_q  <= 1'b0;
    end else begin
      // Integrators and decimation counter.
      if (din_valid) begin
        int1_q      <= int1_d;
        int2_q      <= int2_d;
        int3_q      <= int3_d;
        decim_cnt_q <= decim_cnt_q + RLOG'(1);
      end

      // Tick: capture the newest integrator value and advance warm-up.
      // The first two decimated samples still see the zero history in the
      // comb delays, so only the third tick onward is allowed to strobe.
      if (tick) begin
        comb_in_q <= int3_d;
        if (warm_q != 2'd3) begin
          warm_q <= warm_q + 2'd1;
        end
      end
      stg0_vld_q <= tick;
      stg0_stb_q <= tick && warm_q[1];

      // Comb stage 1.
      if (stg0_vld_q) begin
        comb1_q       <= comb_in_q - comb_in_dly_q;
        comb_in_dly_q <= comb_in_q;
      end
      stg1_vld_q <= stg0_vld_q;
      stg1_stb_q <= stg0_stb_q;

      // Comb stage 2.
      if (stg1_vld_q) begin
        comb2_q     <= comb1_q - comb1_dly_q;
        comb1_dly_q <= comb1_q;
      end
      stg2_vld_q <= stg1_vld_q;
      stg2_stb_q <= stg1_stb_q;

      // Comb stage 3.
      if (stg2_vld_q) begin
        comb3_q     <= comb2_q - comb2_dly_q;
        comb2_dly_q <= comb2_q;
      end
      stg3_vld_q <= stg2_vld_q;
      stg3_stb_q <= stg2_stb_q;

      // Output register: dout only changes together with a strobe.
      dout_valid_q <= stg3_vld_q && stg3_stb_q;
      if (stg3_vld_q && stg3_stb_q) begin
        dout_q <= dout_d;
      end
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;

endmodule

// File: tb/tb_dsm_cic_decimator.sv
// -----------------------------------------------------------------------------
// Testbench for dsm_cic_decimator (RLOG=6, DOUT_W=20).
// Expected samples come from a direct sinc^3 FIR model over the accepted input
// history; they are queued with their due edge when the tick input is driven
// and compared when the DUT strobes.
// -----------------------------------------------------------------------------
module tb_dsm_cic_decimator;

  localparam int RLOG   = 6;
  localparam int DOUT_W = 20;
  localparam int R      = 1 << RLOG;
  localparam int L      = 3 * R - 2;   // sinc^3 impulse response length

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              din = 1'b0;
  logic              din_valid = 1'b0;
  logic [DOUT_W-1:0] dout;
  logic              dout_valid;

  dsm_cic_decimator #(.RLOG(RLOG), .DOUT_W(DOUT_W)) dut (
    .clock      (clock),
    .reset      (reset),
    .din        (din),
    .din_valid  (din_valid),
    .dout       (dout),
    .dout_valid (dout_valid)
  );

  always #5 clock = ~clock;

  int edge_cnt = 0;
  always @(posedge clock) edge_cnt <= edge_cnt + 1;

  typedef struct {
    logic [DOUT_W-1:0] val;
    int                due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;

  int   h[L];
  int   b2[2*R-1];
  bit   hist[$];
  int   vcount = 0;
  int   ticks = 0;
  int   n_strobes = 0;
  int   first_strobe = -1;
  int   last_strobe = -1;
  int   prev_strobe = -1;
  int   rel_edge = 0;

  // Direct FIR evaluation of the newest decimated sample.
  function automatic logic [DOUT_W-1:0] model_out();
    longint      sum;
    logic [63:0] y;
    sum = 0;
    for (int k = 0; k < L; k++) begin
      sum += longint'(h[k]) * longint'(hist[hist.size() - 1 - k]);
    end
    y = 64'(sum) << (DOUT_W - 3 * RLOG);
    if (y > 64'((1 << DOUT_W) - 1)) return '1;
    return y[DOUT_W-1:0];
  endfunction

  // Drive one cycle starting at a negedge; returns at the following negedge.
  task automatic drive(input bit b, input bit v);
    exp_t e;
    din       = b;
    din_valid = v;
    if (v && !reset) begin
      hist.push_back(b);
      if (hist.size() > 3 * R) void'(hist.pop_front());
      vcount++;
      if (vcount == R) begin
        vcount = 0;
        ticks++;
        if (ticks >= 3) begin
          e.val = model_out();
          e.due = edge_cnt + 5;
          sb.push_back(e);
        end
      end
    end
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0);
  endtask

  task automatic apply_reset(input int cycles, input bit valid_during);
    reset     = 1'b1;
    din       = 1'b1;
    din_valid = valid_during;
    while (sb.size() > 0 && sb[sb.size()-1].due > edge_cnt) void'(sb.pop_back());
    hist.delete();
    vcount = 0;
    ticks  = 0;
    repeat (cycles) begin
      @(negedge clock);
      checks++;
      if (dout !== '0) begin
        errors++;
        $display("FAIL reset_dout: got %h want %h", dout, {DOUT_W{1'b0}});
      end
      checks++;
      if (dout_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_dout_valid: got %b want 0", dout_valid);
      end
    end
    reset        = 1'b0;
    din_valid    = 1'b0;
    rel_edge     = edge_cnt;
    n_strobes    = 0;
    first_strobe = -1;
    last_strobe  = -1;
    prev_strobe  = -1;
  endtask

  // Scoreboard monitor: one line per strobe.
  always @(negedge clock) begin
    if (dout_valid === 1'b1) begin
      n_strobes++;
      prev_strobe = last_strobe;
      last_strobe = edge_cnt;
      if (first_strobe < 0) first_strobe = edge_cnt;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_strobe: edge=%0d dout=%h want no strobe", edge_cnt, dout);
      end else begin
        mon_e = sb.pop_front();
        if (dout !== mon_e.val || edge_cnt != mon_e.due) begin
          errors++;
          $display("FAIL strobe: edge=%0d dout=%h want edge=%0d dout=%h",
                   edge_cnt, dout, mon_e.due, mon_e.val);
        end else begin
          $display("strobe edge=%0d dout=%h ok", edge_cnt, dout);
        end
      end
    end else if (sb.size() > 0 && sb[0].due <= edge_cnt) begin
      checks++;
      errors++;
      $display("FAIL missing_strobe: edge=%0d no strobe, want dout=%h at edge=%0d",
               edge_cnt, sb[0].val, sb[0].due);
      void'(sb.pop_front());
    end
  end

  task automatic check_int(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end else begin
      $display("%s: %0d ok", name, got);
    end
  endtask

  task automatic check_dout(input string name, input logic [DOUT_W-1:0] want);
    checks++;
    if (dout !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, dout, want);
    end else begin
      $display("%s: %h ok", name, dout);
    end
  endtask

  task automatic test_reset();
    apply_reset(3, 1'b1);
  endtask

  task automatic test_ones();
    apply_reset(2, 1'b0);
    repeat (1000) drive(1'b1, 1'b1);
    idle(6);
    check_int("ones_first_strobe_latency", first_strobe - rel_edge, 3 * R + 4);
    check_int("ones_strobe_count", n_strobes, 13);
    check_int("ones_strobe_spacing", last_strobe - prev_strobe, R);
    check_dout("ones_dout", 20'hFFFFF);
  endtask

  task automatic test_zeros();
    apply_reset(2, 1'b0);
    repeat (8 * R) drive(1'b0, 1'b1);
    idle(6);
    check_int("zeros_strobe_count", n_strobes, 6);
    check_dout("zeros_dout", 20'h00000);
  endtask

  task automatic test_patterns();
    apply_reset(2, 1'b0);
    for (int i = 0; i < 8 * R; i++) drive(((i % 2) == 0), 1'b1);
    idle(6);
    check_int("alt_strobe_count", n_strobes, 6);
    check_dout("alt_dout", 20'h80000);
    apply_reset(2, 1'b0);
    for (int i = 0; i < 8 * R; i++) drive(((i % 4) == 0), 1'b1);
    idle(6);
    check_int("quarter_strobe_count", n_strobes, 6);
    check_dout("quarter_dout", 20'h40000);
  endtask

  task automatic test_gaps();
    bit rb;
    apply_reset(2, 1'b0);
    for (int i = 0; i < 3 * 5 * R; i++) begin
      rb = 1'($urandom_range(0, 1));
      if ((i % 3) == 0) drive(1'b1, 1'b1);
      else drive(rb, 1'b0);
    end
    idle(6);
    check_int("gaps_strobe_count", n_strobes, 3);
    check_int("gaps_strobe_spacing", last_strobe - prev_strobe, 3 * R);
    check_dout("gaps_dout", 20'hFFFFF);
  endtask

  task automatic test_long_wrap();
    apply_reset(2, 1'b0);
    repeat (20000) drive(1'b1, 1'b1);
    idle(6);
    check_int("wrap_strobe_count", n_strobes, (20000 / R) - 2);
    check_dout("wrap_dout", 20'hFFFFF);
  endtask

  task automatic test_random();
    bit rb;
    bit rv;
    apply_reset(2, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      rb = 1'($urandom_range(0, 1));
      rv = ($urandom_range(0, 3) != 0);
      drive(rb, rv);
    end
    idle(6);
    check_int("random_strobe_count", n_strobes, (ticks >= 3) ? ticks - 2 : 0);
  endtask

  task automatic test_reset_midframe();
    apply_reset(2, 1'b0);
    repeat (30) drive(1'b1, 1'b1);
    apply_reset(1, 1'b1);
    repeat (3 * R - 1) drive(1'b1, 1'b1);
    idle(6);
    check_int("midframe_no_early_strobe", n_strobes, 0);
    drive(1'b1, 1'b1);
    idle(6);
    check_int("midframe_first_strobe", n_strobes, 1);
    check_dout("midframe_dout", 20'hFFFFF);
  endtask

  task automatic test_inflight_reset();
    apply_reset(2, 1'b0);
    repeat (3 * R) drive(1'b1, 1'b1);
    drive(1'b1, 1'b0);
    apply_reset(3, 1'b0);
    idle(8);
    check_int("inflight_strobe_suppressed", n_strobes, 0);
  endtask

  initial begin
    for (int i = 0; i < 2 * R - 1; i++) b2[i] = 0;
    for (int i = 0; i < L; i++) h[i] = 0;
    for (int i = 0; i < R; i++)
      for (int j = 0; j < R; j++) b2[i + j] += 1;
    for (int i = 0; i < 2 * R - 1; i++)
      for (int j = 0; j < R; j++) h[i + j] += b2[i];

    @(negedge clock);
    test_reset();
    test_ones();
    test_zeros();
    test_patterns();
    test_gaps();
    test_long_wrap();
    test_random();
    test_reset_midframe();
    test_inflight_reset();
    idle(8);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
